mix_columns_iter: RTL and testbench

MIX_COLUMNS_ITER -- requirements
Module: mix_columns_iter

---
 rtl/aes_pkg.sv | 37 +++
 rtl/mix_column_word.sv | 32 +++
 rtl/mix_columns_iter.sv | 112 +++++++++++
 tb/tb_mix_columns_iter.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants and GF(2^8) helpers (reduction polynomial 0x11b).
package aes_pkg;

  localparam int unsigned AES_STATE_W = 128;
  localparam int unsigned AES_COL_W   = 32;
  localparam int unsigned AES_NCOL    = 4;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul_2(input logic [7:0] b);
    return xtime(b);
  endfunction

  function automatic logic [7:0] gf_mul_3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

  // Inverse-matrix constants built from x2, x4, x8 partial products.
  function automatic logic [7:0] gf_mul_9(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] gf_mul_b(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gf_mul_d(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] gf_mul_e(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

endpackage

// File: rtl/mix_column_word.sv
// Combinational MixColumns / InvMixColumns of one 32-bit column (row 0 in MSB).
module mix_column_word
  import aes_pkg::*;
(
  input  logic                 inv_i,
  input  logic [AES_COL_W-1:0] col_i,
  output logic [AES_COL_W-1:0] mixed_c
);

  logic [7:0] a [4];
  logic [7:0] res;

  always_comb begin
    mixed_c = '0;
    res     = '0;
    for (int unsigned r = 0; r < 4; r++) begin
      a[r] = col_i[AES_COL_W-1-8*r -: 8];
    end
    // Row r uses the base matrix row rotated right by r.
    for (int unsigned r = 0; r < 4; r++) begin
      if (inv_i) begin
        res = gf_mul_e(a[2'(r)]) ^ gf_mul_b(a[2'(r+1)]) ^
              gf_mul_d(a[2'(r+2)]) ^ gf_mul_9(a[2'(r+3)]);
      end else begin
        res = gf_mul_2(a[2'(r)]) ^ gf_mul_3(a[2'(r+1)]) ^
              a[2'(r+2)] ^ a[2'(r+3)];
      end
      mixed_c[AES_COL_W-1-8*r -: 8] = res;
    end
  end

endmodule

// File: rtl/mix_columns_iter.sv
// Iterative MixColumns/InvMixColumns over a 128-bit AES state, COLS_PER_CYCLE columns per edge.
module mix_columns_iter
  import aes_pkg::*;
#(
  parameter int unsigned COLS_PER_CYCLE = 1,
  parameter int unsigned INV_EN         = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   inv,
  input  logic [AES_STATE_W-1:0] state_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_STATE_W-1:0] state_out,
  output logic                   busy
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cpc
    $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e                        state_q, state_d;
  logic [1:0]                    cnt_q, cnt_d;
  logic                          inv_q, inv_d;
  logic [AES_NCOL-1:0][AES_COL_W-1:0] work_q, work_d, work_next;
  logic [AES_STATE_W-1:0]        out_q, out_d;

  logic [COLS_PER_CYCLE-1:0][AES_COL_W-1:0] col_in, col_out;
  logic [1:0]                    idx [COLS_PER_CYCLE];
  logic                          last_c;

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign state_out = out_q;
  assign last_c    = ({1'b0, cnt_q} + 3'(COLS_PER_CYCLE)) == 3'd4;

  // Column c lives in packed slot 3-c so the MSB word is column 0.
  for (genvar k = 0; k < int'(COLS_PER_CYCLE); k++) begin : g_col
    assign idx[k]    = 2'd3 - (cnt_q + 2'(k));
    assign col_in[k] = work_q[idx[k]];
    mix_column_word u_mcw (
      .inv_i   (inv_q),
      .col_i   (col_in[k]),
      .mixed_c (col_out[k])
    );
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    inv_d     = inv_q;
    work_d    = work_q;
    out_d     = out_q;
    work_next = work_q;
    for (int unsigned k = 0; k < COLS_PER_CYCLE; k++) begin
      work_next[idx[k]] = col_out[k];
    end
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = CALC;
          cnt_d   = '0;
          inv_d   = (INV_EN != 0) && inv;
          work_d  = state_in;
        end
      end
      CALC: begin
        work_d = work_next;
        cnt_d  = cnt_q + 2'(COLS_PER_CYCLE);
        if (last_c) begin
          state_d = DONE;
          out_d   = work_next;
        end
      end
      DONE: begin
        if (out_ready) begin
          if (in_valid) begin
            state_d = CALC;
            cnt_d   = '0;
            inv_d   = (INV_EN != 0) && inv;
            work_d  = state_in;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      inv_q   <= 1'b0;
      work_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      inv_q   <= inv_d;
      work_q  <= work_d;
      out_q   <= out_d;
    end
  end

endmodule

// File: tb/tb_mix_columns_iter.sv
// Bench for mix_columns_iter: CPC=1/2/4 and an INV_EN=0 instance driven side by side.
module tb_mix_columns_iter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   iv;
  logic [3:0]   ir;
  logic         inv;
  logic [127:0] state_in;
  logic [3:0]   ov;
  logic         out_ready;
  logic [127:0] so [4];
  logic [3:0]   bz;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  mix_columns_iter #(.COLS_PER_CYCLE(1), .INV_EN(1)) u_c1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .inv(inv),
    .state_in(state_in), .out_valid(ov[0]), .out_ready(out_ready),
    .state_out(so[0]), .busy(bz[0]));
  mix_columns_iter #(.COLS_PER_CYCLE(2), .INV_EN(1)) u_c2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .inv(inv),
    .state_in(state_in), .out_valid(ov[1]), .out_ready(out_ready),
    .state_out(so[1]), .busy(bz[1]));
  mix_columns_iter #(.COLS_PER_CYCLE(4), .INV_EN(1)) u_c4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .inv(inv),
    .state_in(state_in), .out_valid(ov[2]), .out_ready(out_ready),
    .state_out(so[2]), .busy(bz[2]));
  mix_columns_iter #(.COLS_PER_CYCLE(1), .INV_EN(0)) u_fwd (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]), .inv(inv),
    .state_in(state_in), .out_valid(ov[3]), .out_ready(out_ready),
    .state_out(so[3]), .busy(bz[3]));

  typedef struct {
    logic [127:0] din;
    logic         inv;
    logic         chk012;
    logic [127:0] exp;
    logic         chk3;
    logic [127:0] exp3;
    int           stall;
  } vec_t;

  vec_t vecs [6];
  int   exp_lat [4];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int   lat [4];
    logic sel;
    logic [127:0] e;
    state_in  = v.din;
    inv       = v.inv;
    iv        = '1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    iv       = '0;
    state_in = ~v.din;
    inv      = ~v.inv;
    lat      = '{0, 0, 0, 0};
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 4; i++) if (ov[i] && lat[i] == 0) lat[i] = n;
    end
    for (int i = 0; i < 4; i++) begin
      sel = (i < 3) ? v.chk012 : v.chk3;
      e   = (i < 3) ? v.exp : v.exp3;
      if (sel) begin
        chk($sformatf("v%0d dut%0d latency", id, i), 128'(lat[i]), 128'(exp_lat[i]));
        chk($sformatf("v%0d dut%0d state_out", id, i), so[i], e);
        chk($sformatf("v%0d dut%0d in_ready stalled", id, i), 128'(ir[i]), 128'(0));
        chk($sformatf("v%0d dut%0d busy", id, i), 128'(bz[i]), 128'(1));
      end
    end
    // Stalled DONE: input activity must not disturb the held result.
    for (int s = 0; s < v.stall; s++) begin
      @(posedge clk); #1;
      state_in = {$urandom, $urandom, $urandom, $urandom};
      inv      = ~inv;
      iv       = '1;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        sel = (i < 3) ? v.chk012 : v.chk3;
        e   = (i < 3) ? v.exp : v.exp3;
        if (sel) begin
          chk($sformatf("v%0d dut%0d stall%0d state_out", id, i, s), so[i], e);
          chk($sformatf("v%0d dut%0d stall%0d out_valid", id, i, s), 128'(ov[i]), 128'(1));
          chk($sformatf("v%0d dut%0d stall%0d in_ready", id, i, s), 128'(ir[i]), 128'(0));
        end
      end
    end
    @(posedge clk); #1;
    iv        = '0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d out_valid after release", id), 128'(ov), 128'(0));
    chk($sformatf("v%0d busy after release", id), 128'(bz), 128'(0));
    chk($sformatf("v%0d in_ready after release", id), 128'(ir), 128'hf);
  endtask

  initial begin
    logic [127:0] b2b_in  [3];
    logic [127:0] b2b_exp [3];
    int nres, nacc, last_cyc;
    logic acc;

    exp_lat = '{4, 2, 1, 4};
    vecs[0] = '{128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b0, 1'b1,
                128'h046681e5e0cb199a48f8d37a2806264c, 1'b1,
                128'h046681e5e0cb199a48f8d37a2806264c, 0};
    vecs[1] = '{128'h046681e5e0cb199a48f8d37a2806264c, 1'b1, 1'b1,
                128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b0, 128'h0, 0};
    vecs[2] = '{128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b1, 1'b0, 128'h0, 1'b1,
                128'h046681e5e0cb199a48f8d37a2806264c, 0};
    vecs[3] = '{128'hdb135345f20a225c01010101c6c6c6c6, 1'b0, 1'b1,
                128'h8e4da1bc9fdc589d01010101c6c6c6c6, 1'b1,
                128'h8e4da1bc9fdc589d01010101c6c6c6c6, 5};
    vecs[4] = '{128'h8e4da1bc9fdc589d01010101c6c6c6c6, 1'b1, 1'b1,
                128'hdb135345f20a225c01010101c6c6c6c6, 1'b0, 128'h0, 0};
    vecs[5] = '{128'hd4d4d4d52d26314c00000000ffffffff, 1'b0, 1'b1,
                128'hd5d5d7d64d7ebdf800000000ffffffff, 1'b1,
                128'hd5d5d7d64d7ebdf800000000ffffffff, 0};

    rst_n = 1'b0; iv = '0; inv = 1'b0; state_in = '0; out_ready = 1'b0;
    #12;
    chk("reset out_valid", 128'(ov), 128'(0));
    chk("reset busy", 128'(bz), 128'(0));
    chk("reset in_ready", 128'(ir), 128'hf);
    for (int i = 0; i < 4; i++) chk($sformatf("reset dut%0d state_out", i), so[i], 128'h0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("post-reset in_ready", 128'(ir), 128'hf);

    for (int t = 0; t < 6; t++) run_vec(vecs[t], t);

    // Back-to-back on the CPC=1 instance only.
    b2b_in[0] = vecs[0].din; b2b_exp[0] = vecs[0].exp;
    b2b_in[1] = vecs[3].din; b2b_exp[1] = vecs[3].exp;
    b2b_in[2] = vecs[5].din; b2b_exp[2] = vecs[5].exp;
    nres = 0; nacc = 0; last_cyc = 0;
    @(posedge clk); #1;
    state_in = b2b_in[0]; inv = 1'b0; iv = 4'b0001; out_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && nres < 3; cyc++) begin
      @(negedge clk);
      if (ov[0]) begin
        chk($sformatf("b2b result%0d", nres), so[0], b2b_exp[nres]);
        if (nres > 0) chk($sformatf("b2b spacing%0d", nres), 128'(cyc - last_cyc), 128'(5));
        last_cyc = cyc;
        nres++;
      end
      acc = ir[0] && iv[0];
      @(posedge clk); #1;
      if (acc) begin
        nacc++;
        if (nacc < 3) state_in = b2b_in[nacc];
        else iv = '0;
      end
    end
    chk("b2b result count", 128'(nres), 128'(3));
    chk("b2b accept count", 128'(nacc), 128'(3));
    @(negedge clk);
    chk("b2b no duplicate", 128'(ov[0]), 128'(0));
    out_ready = 1'b0;

    // Reset two columns into a CALC on the CPC=1 instance.
    @(posedge clk); #1;
    state_in = vecs[3].din; inv = 1'b0; iv = '1;
    @(posedge clk); #1;
    iv = '0;
    @(posedge clk);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("midreset out_valid", 128'(ov), 128'(0));
    chk("midreset busy", 128'(bz), 128'(0));
    chk("midreset in_ready", 128'(ir), 128'hf);
    for (int i = 0; i < 4; i++) chk($sformatf("midreset dut%0d state_out", i), so[i], 128'h0);
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("post-midreset out_valid c%0d", c), 128'(ov), 128'(0));
    end
    run_vec(vecs[0], 10);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
